// File: rtl/rotate_scheduler.sv
// Two-port round-robin front end for a shared 32-bit barrel rotator.
// Each result is registered, tagged with the requester id and held under backpressure.
module rotate_scheduler #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_o,
  output logic             out_id,
  output logic [CNTW-1:0]  ops_done
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic [WIDTH-1:0] r_o;
  logic             r_id;
  logic [CNTW-1:0]  r_ops;

  logic             w_g0;
  logic             w_g1;
  logic             w_free;
  logic             w_acc;
  logic             w_cons;
  logic [WIDTH-1:0] w_a;
  logic [SHW-1:0]   w_k;
  logic             w_dir;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_rot;
  logic             w_unused;

  // Upper amount bits carry no meaning for a rotate.
  assign w_unused = ^{req0_b[WIDTH-1:SHW], req1_b[WIDTH-1:SHW]};

  // Round-robin: on contention the requester not served last wins.
  always_comb begin
    w_g0 = req0_valid && (!req1_valid || r_last);
    w_g1 = req1_valid && (!req0_valid || !r_last);
  end

  assign out_valid  = (r_state == FULL);
  assign w_free     = !out_valid || out_ready;
  assign req0_ready = w_g0 && w_free && !rst;
  assign req1_ready = w_g1 && w_free && !rst;
  assign w_acc      = (req0_valid && req0_ready) ||
                      (req1_valid && req1_ready);
  assign w_cons     = out_valid && out_ready;

  // Operand mux for the granted requester.
  always_comb begin
    w_a   = req0_a;
    w_k   = req0_b[SHW-1:0];
    w_dir = req0_dir;
    if (w_g1) begin
      w_a   = req1_a;
      w_k   = req1_b[SHW-1:0];
      w_dir = req1_dir;
    end
  end

  // Left rotate by k is right rotate by (WIDTH-k) mod WIDTH.
  assign w_amt = w_dir ? (~w_k + 1'b1) : w_k;

  for (genvar s = 0; s < SHW; s++) begin : g_rot
    localparam int SH = 1 << s;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_out;
    if (s == 0) begin : g_first
      assign w_in = w_a;
    end else begin : g_next
      assign w_in = g_rot[s-1].w_out;
    end
    assign w_out = w_amt[s] ?
      {w_in[SH-1:0], w_in[WIDTH-1:SH]} : w_in;
  end

  assign w_rot = g_rot[SHW-1].w_out;

  // Output slot occupancy.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: if (w_acc) w_state_nxt = FULL;
      FULL:  if (out_ready && !w_acc) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Result register and arbiter history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o    <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_o    <= w_rot;
      r_id   <= w_g1;
      r_last <= w_g1;
    end
  end

  // Consumed-result counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         r_ops <= '0;
    else if (w_cons) r_ops <= r_ops + 1'b1;
  end

  assign out_o    = r_o;
  assign out_id   = r_id;
  assign ops_done = r_ops;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Directed bench for rotate_scheduler.
// Counter width reduced to 4 bits so wrap-around is reachable.
module tb_rotate_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_dir;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_dir;
  logic [31:0] req1_a, req1_b;
  logic        out_valid, out_ready, out_id;
  logic [31:0] out_o;
  logic [3:0]  ops_done;

  int checks = 0;
  int errors = 0;
  bit m_valid = 1'b0;
  int exp_done = 0;
  logic [3:0] exp_cnt;
  bit g;
  logic [31:0] hold_o;
  logic hold_id;
  logic [31:0] amt_b [5];
  logic [31:0] amt_e [5];

  rotate_scheduler #(.WIDTH(32), .SHW(5), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_dir(req1_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_o(out_o), .out_id(out_id), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rot_ref(logic [31:0] a, int k, bit d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      if (!d) r[i] = a[(i + k) % 32];
      else    r[(i + k) % 32] = a[i];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; bench-side model of slot occupancy and consumed count.
  task automatic step(input bit acc);
    if (rst) begin
      m_valid  = 1'b0;
      exp_done = 0;
    end else begin
      if (m_valid && out_ready) exp_done++;
      m_valid = acc || (m_valid && !out_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    exp_cnt = exp_done[3:0];
    chk(tag, {28'd0, ops_done}, {28'd0, exp_cnt});
    chk({tag, "_v"}, {31'd0, out_valid}, {31'd0, m_valid});
  endtask

  initial begin
    amt_b[0] = 32'd0;        amt_e[0] = 32'h12345678;
    amt_b[1] = 32'd6;        amt_e[1] = 32'hE048D159;
    amt_b[2] = 32'd16;       amt_e[2] = 32'h56781234;
    amt_b[3] = 32'd31;       amt_e[3] = 32'h2468ACF0;
    amt_b[4] = 32'hFFFFFFE4; amt_e[4] = 32'h81234567;

    rst = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_dir = 1'b0;
    out_ready = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ops", {28'd0, ops_done}, 32'd0);
    chk("rst_o", out_o, 32'd0);

    rst = 1'b0;
    #1;
    chk("first_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("first_rdy1", {31'd0, req1_ready}, 32'd0);

    req1_valid = 1'b0;
    req0_a = 32'h80000001; req0_b = 32'd1; req0_dir = 1'b0;
    out_ready = 1'b1;
    step(1'b1);
    chk("rr1_o", out_o, 32'hC0000000);
    chk("rr1_id", {31'd0, out_id}, 32'd0);
    chk("rr1_v", {31'd0, out_valid}, 32'd1);
    req0_dir = 1'b1;
    step(1'b1);
    chk("rl1_o", out_o, 32'h00000003);
    chk_cnt("ops_a");

    req0_a = 32'h12345678; req0_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req0_b = amt_b[i];
      step(1'b1);
      chk($sformatf("amt%0d", i), out_o, amt_e[i]);
    end

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 32; k++) begin
        req0_a = 32'h9E3779B9 ^ (32'h01010101 * k);
        req0_b = 32'hA5A5A5A0 & ~32'h1F | k;
        req0_dir = d[0];
        step(1'b1);
        chk($sformatf("sweep_d%0d_k%0d", d, k), out_o,
            rot_ref(req0_a, k, d[0]));
      end
    end
    chk_cnt("ops_b");

    // Last winner was requester 0, so contention starts with 1.
    req0_a = 32'h11; req0_b = '0; req0_dir = 1'b0;
    req1_a = 32'h22; req1_b = 32'd4; req1_dir = 1'b1;
    req1_valid = 1'b1;
    g = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), {31'd0, req0_ready}, {31'd0, !g});
      chk($sformatf("rr_rdy1_%0d", i), {31'd0, req1_ready}, {31'd0, g});
      step(1'b1);
      chk($sformatf("rr_id_%0d", i), {31'd0, out_id}, {31'd0, g});
      chk($sformatf("rr_o_%0d", i), out_o, g ? 32'h220 : 32'h11);
      g = !g;
    end
    chk_cnt("ops_rr");

    // g is now 1: requester 1 wins, then the slot is blocked.
    step(1'b1);
    hold_o = 32'h220; hold_id = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_rdy0_%0d", i), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp_rdy1_%0d", i), {31'd0, req1_ready}, 32'd0);
      step(1'b0);
      chk($sformatf("bp_o_%0d", i), out_o, hold_o);
      chk($sformatf("bp_id_%0d", i), {31'd0, out_id}, {31'd0, hold_id});
      chk($sformatf("bp_v_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("drain_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("drain_rdy1", {31'd0, req1_ready}, 32'd0);
    step(1'b1);
    chk("drain_id", {31'd0, out_id}, 32'd0);
    chk("drain_o", out_o, 32'h11);
    chk_cnt("ops_drain");

    // Reset with a pending result; last winner was 0.
    out_ready = 1'b0;
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    chk("mrst_v", {31'd0, out_valid}, 32'd0);
    chk("mrst_ops", {28'd0, ops_done}, 32'd0);
    #1;
    chk("mrst_rdy0", {31'd0, req0_ready}, 32'd1);
    chk("mrst_rdy1", {31'd0, req1_ready}, 32'd0);

    req1_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1);
    req0_valid = 1'b0;
    step(1'b0);
    chk("wrap_ops", {28'd0, ops_done}, 32'd1);
    chk("wrap_v", {31'd0, out_valid}, 32'd0);
    chk_cnt("ops_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
